// File: rtl/clk_tree_seq_ctrl.sv
// Reset/ratio sequencer for the div2 ripple chain: gates the downstream clock, resets the chain,
// switches the output tap, releases stages first-to-last, waits to settle, then ungates.
module clk_tree_seq_ctrl #(
  parameter int N_STAGES   = 8,
  parameter int SEL_W      = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                cfg_valid,
  input  logic [SEL_W-1:0]    cfg_sel,
  output logic                cfg_ready,
  output logic [N_STAGES-1:0] stage_rstb,
  output logic [SEL_W-1:0]    tap_sel,
  output logic                clk_en,
  output logic                busy,
  output logic                done
);

  localparam int                  CNT_W     = $clog2(SETTLE_CYC + 2);
  localparam logic [CNT_W-1:0]    GATE_LOAD = CNT_W'(1);
  localparam logic [CNT_W-1:0]    HOLD_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_STAGES-1:0] ALL_ONES  = '1;
  localparam logic [N_STAGES-1:0] FIRST_BIT = N_STAGES'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GATE    = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    SETTLE  = 3'd4
  } state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [N_STAGES-1:0]   stage_rstb_d;
  logic [SEL_W-1:0]      tap_sel_d;
  logic                  clk_en_d;
  logic                  cfg_ready_d;
  logic                  busy_d;
  logic                  done_d;

  // Out-of-range tap requests select the slowest available tap.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if (int'(s) >= N_STAGES) return SEL_W'(N_STAGES - 1);
    return s;
  endfunction

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    sel_d        = sel_q;
    stage_rstb_d = stage_rstb;
    tap_sel_d    = tap_sel;
    clk_en_d     = clk_en;
    cfg_ready_d  = cfg_ready;
    busy_d       = busy;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          state_d     = GATE;
          cnt_d       = GATE_LOAD;
          sel_d       = clamp_sel(cfg_sel);
          clk_en_d    = 1'b0;
          cfg_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      GATE: begin
        if (cnt == '0) begin
          state_d      = HOLD;
          cnt_d        = HOLD_LOAD;
          stage_rstb_d = '0;
          tap_sel_d    = sel_q;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_d      = RELEASE;
          stage_rstb_d = FIRST_BIT;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RELEASE: begin
        // One more stage comes out of reset per cycle, first stage first.
        if (stage_rstb == ALL_ONES) begin
          state_d = SETTLE;
          cnt_d   = HOLD_LOAD;
        end else begin
          stage_rstb_d = (stage_rstb << 1) | FIRST_BIT;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_d     = IDLE;
          clk_en_d    = 1'b1;
          done_d      = 1'b1;
          cfg_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
      end
    endcase
  end

  // Reset counts as the first HOLD cycle of the boot sequence for tap 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= HOLD;
      cnt        <= HOLD_LOAD;
      sel_q      <= '0;
      stage_rstb <= '0;
      tap_sel    <= '0;
      clk_en     <= 1'b0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sel_q      <= sel_d;
      stage_rstb <= stage_rstb_d;
      tap_sel    <= tap_sel_d;
      clk_en     <= clk_en_d;
      cfg_ready  <= cfg_ready_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_clk_tree_seq_ctrl.sv
// Bench for clk_tree_seq_ctrl: an 8-stage and a 6-stage instance share stimulus and are checked
// every cycle against a phase-timeline model, plus literal spot checks.
module tb_clk_tree_seq_ctrl;

  localparam int SC = 4;
  localparam int NS[2] = '{8, 6};

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_sel = 3'd0;

  logic       rdy8, ce8, busy8, done8;
  logic [7:0] sr8;
  logic [2:0] tap8;
  logic       rdy6, ce6, busy6, done6;
  logic [5:0] sr6;
  logic [2:0] tap6;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: each DUT runs a timeline starting at start[d]; gl = gate length (0 for boot).
  int start[2] = '{0, 0};
  int gl[2]    = '{0, 0};
  int sel_m[2] = '{0, 0};
  int old_m[2] = '{0, 0};
  logic       prev_ce[2]  = '{1'b0, 1'b0};
  logic [2:0] prev_tap[2] = '{3'd0, 3'd0};

  clk_tree_seq_ctrl #(.N_STAGES(8), .SEL_W(3), .SETTLE_CYC(SC)) dut8 (
    .clk(clk), .rstb(rstb), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_ready(rdy8),
    .stage_rstb(sr8), .tap_sel(tap8), .clk_en(ce8), .busy(busy8), .done(done8));

  clk_tree_seq_ctrl #(.N_STAGES(6), .SEL_W(3), .SETTLE_CYC(SC)) dut6 (
    .clk(clk), .rstb(rstb), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_ready(rdy6),
    .stage_rstb(sr6), .tap_sel(tap6), .clk_en(ce6), .busy(busy6), .done(done6));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rstb) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstb) begin
        start[d] <= cyc + 1;
        gl[d]    <= 0;
        sel_m[d] <= 0;
      end else if ((cyc - start[d] >= gl[d] + 2 * SC + NS[d]) && cfg_valid) begin
        old_m[d] <= sel_m[d];
        sel_m[d] <= (int'(cfg_sel) >= NS[d]) ? NS[d] - 1 : int'(cfg_sel);
        gl[d]    <= 2;
        start[d] <= cyc + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_chk(input int d, input logic rdy, input logic ce, input logic bsy,
                           input logic dn, input logic [7:0] sr, input logic [2:0] tap);
    int k, n, g, len, all1, e_sr, e_tap;
    logic e_ce, e_rdy, e_busy, e_done;
    logic [14:0] act, exp;
    k = cyc - start[d];
    n = NS[d];
    g = gl[d];
    len = g + 2 * SC + n;
    all1 = (1 << n) - 1;
    e_sr = all1; e_tap = sel_m[d];
    e_ce = 1'b0; e_rdy = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    if (k < g) e_tap = old_m[d];
    else if (k < g + SC) e_sr = 0;
    else if (k < g + SC + n) e_sr = (1 << (k - g - SC + 1)) - 1;
    else if (k >= len) begin
      e_ce = 1'b1; e_rdy = 1'b1; e_busy = 1'b0; e_done = (k == len);
    end
    act = {sr, tap, ce, rdy, bsy, dn};
    exp = {8'(e_sr), 3'(e_tap), e_ce, e_rdy, e_busy, e_done};
    chk(d == 0 ? "model8 {sr,tap,ce,rdy,busy,done}" : "model6 {sr,tap,ce,rdy,busy,done}",
        int'(act), int'(exp));
    chk(d == 0 ? "inv8 clk_en with stage in reset" : "inv6 clk_en with stage in reset",
        int'(ce && (int'(sr) != all1)), 0);
    chk(d == 0 ? "inv8 tap change while clk_en" : "inv6 tap change while clk_en",
        int'(prev_ce[d] && ce && (tap != prev_tap[d])), 0);
    prev_ce[d]  = ce;
    prev_tap[d] = tap;
  endtask

  always @(negedge clk) begin
    model_chk(0, rdy8, ce8, busy8, done8, sr8, tap8);
    model_chk(1, rdy6, ce6, busy6, done6, {2'b00, sr6}, tap6);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench just after the accept edge E0.
  task automatic request(input logic [2:0] s);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_sel   = s;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Boot
    tick(3);
    rstb = 1'b1;
    tick(3);
    chk("boot edge3 stage_rstb", sr8, 8'h00);
    chk("boot edge3 clk_en", ce8, 0);
    tick(1);
    chk("boot edge4 stage_rstb", sr8, 8'h01);
    tick(7);
    chk("boot edge11 stage_rstb", sr8, 8'hFF);
    chk("boot edge11 clk_en", ce8, 0);
    tick(3);
    chk("boot6 edge14 done", done6, 1);
    chk("boot8 edge14 done", done8, 0);
    tick(2);
    chk("boot edge16 done", done8, 1);
    chk("boot edge16 clk_en", ce8, 1);
    tick(1);
    chk("boot edge17 cfg_ready", rdy8, 1);
    chk("boot edge17 done cleared", done8, 0);

    // Reprogram to tap 3
    request(3'd3);
    chk("reprog E0 cfg_ready", rdy8, 0);
    chk("reprog E0 clk_en", ce8, 0);
    tick(2);
    chk("reprog E2 tap_sel", tap8, 3);
    chk("reprog E2 stage_rstb", sr8, 8'h00);
    tick(16);
    chk("reprog E18 done", done8, 1);
    chk("reprog E18 busy", busy8, 0);

    // Clamp on the 6-stage instance
    request(3'd7);
    tick(2);
    chk("clamp6 E2 tap_sel", tap6, 5);
    chk("noclamp8 E2 tap_sel", tap8, 7);
    tick(13);
    chk("clamp6 E15 busy", busy6, 1);
    tick(1);
    chk("clamp6 E16 done", done6, 1);
    tick(2);

    // Request while busy, held through completion
    request(3'd1);
    tick(7);
    cfg_valid = 1'b1;
    cfg_sel   = 3'd2;
    tick(6);
    chk("busyreq E13 tap_sel", tap8, 1);
    tick(5);
    chk("busyreq E18 done", done8, 1);
    chk("busyreq E18 tap_sel", tap8, 1);
    tick(1);
    chk("busyreq E19 accepted", rdy8, 0);
    cfg_valid = 1'b0;
    tick(1);
    chk("busyreq E20 tap_sel", tap8, 1);
    tick(1);
    chk("busyreq E21 tap_sel", tap8, 2);
    tick(20);

    // Mid-sequence reset
    request(3'd4);
    tick(8);
    #2 rstb = 1'b0;
    #1;
    chk("midrst stage_rstb", sr8, 8'h00);
    chk("midrst tap_sel", tap8, 0);
    chk("midrst clk_en", ce8, 0);
    chk("midrst busy", busy8, 1);
    tick(3);
    rstb = 1'b1;
    tick(16);
    chk("midrst boot done", done8, 1);
    chk("midrst boot tap_sel", tap8, 0);

    // Random traffic with occasional resets
    repeat (800) begin
      @(negedge clk);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_sel   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) begin
        #2 rstb = 1'b0;
        tick($urandom_range(1, 3));
        rstb = 1'b1;
      end
    end
    cfg_valid = 1'b0;
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
